// File: rtl/tinygzip_feeder.sv
`default_nettype none
// =====================================================================
// tinygzip_feeder: request FIFO and issue/return adapter for tinygzip.
// Optional watchdog macro: TINYGZIP_FEEDER_WATCHDOG_EN.      Rev 1.0
// =====================================================================
module tinygzip_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1,
  input  logic [4:0]  in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rd,
  output logic        unit_start,
  output logic [31:0] unit_rs1,
  output logic [4:0]  unit_rs2,
  input  logic [31:0] unit_rd,
  input  logic        unit_busy,
  input  logic        unit_done,
  output logic        err
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  logic [36:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic slot_free;
  logic issue_ok;
  logic wd_expire;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign slot_free = !out_valid || out_ready;
  assign issue_ok  = (state == IDLE) && !empty && !unit_busy && slot_free;
  assign pop       = issue_ok;

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_rs2, in_rs1};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      unit_start <= 1'b0;
      unit_rs1   <= '0;
      unit_rs2   <= '0;
      out_valid  <= 1'b0;
      out_rd     <= '0;
    end else begin
      unit_start <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          // A done seen here is stale and deliberately ignored.
          if (issue_ok) begin
            unit_start             <= 1'b1;
            {unit_rs2, unit_rs1}   <= fifo_mem[rd_ptr];
            state                  <= WAIT;
          end
        end
        WAIT: begin
          if (unit_done) begin
            out_rd    <= unit_rd;
            out_valid <= 1'b1;
            state     <= IDLE;
          end else if (wd_expire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TINYGZIP_FEEDER_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_count;

  // Expire on the edge where the count would reach TIMEOUT.
  assign wd_expire = (state == WAIT) && !unit_done && (wd_count == WD_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_count <= '0;
      err      <= 1'b0;
    end else begin
      if (issue_ok) begin
        wd_count <= '0;
      end else if (state == WAIT) begin
        wd_count <= wd_count + WD_W'(1);
      end
      if (wd_expire || ((state == IDLE) && unit_done)) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign wd_expire  = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = ^TIMEOUT;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tinygzip_feeder.sv
`default_nettype none
// Directed bench for tinygzip_feeder with a 5-cycle behavioural tinygzip model.
module tb_tinygzip_feeder;

  logic        clock     = 1'b0;
  logic        resetn    = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_rs1    = '0;
  logic [4:0]  in_rs2    = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_rd;
  logic        unit_start;
  logic [31:0] unit_rs1;
  logic [4:0]  unit_rs2;
  logic [31:0] unit_rd;
  logic        unit_busy;
  logic        unit_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int rx     = 0;
  int pushes = 0;
  logic [31:0] exp_q[$];
  logic        record_push = 1'b1;
  logic        rand_ready  = 1'b0;
  logic        no_done     = 1'b0;
  logic        force_done  = 1'b0;
  logic [31:0] force_rd    = '0;

  tinygzip_feeder dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .unit_start (unit_start),
    .unit_rs1   (unit_rs1),
    .unit_rs2   (unit_rs2),
    .unit_rd    (unit_rd),
    .unit_busy  (unit_busy),
    .unit_done  (unit_done),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Unit model: busy for 5 cycles after start, done in the last one.
  logic        mbusy;
  int          rem;
  logic [31:0] mres;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mbusy <= 1'b0;
      rem   <= 0;
      mres  <= '0;
    end else if (unit_start && !mbusy) begin
      mbusy <= 1'b1;
      rem   <= 5;
      mres  <= unit_rs1 ^ {27'b0, unit_rs2};
    end else if (mbusy) begin
      if (rem == 1) mbusy <= 1'b0;
      else          rem   <= rem - 1;
    end
  end

  assign unit_busy = mbusy;
  assign unit_done = (mbusy && (rem == 1) && !no_done) || force_done;
  assign unit_rd   = force_done ? force_rd : ((mbusy && (rem == 1)) ? mres : 32'h0);

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset_values(input string tag);
    chk1 ({tag, "_in_ready"},   in_ready,   1'b1);
    chk1 ({tag, "_out_valid"},  out_valid,  1'b0);
    chk32({tag, "_out_rd"},     out_rd,     32'h0);
    chk1 ({tag, "_unit_start"}, unit_start, 1'b0);
    chk32({tag, "_unit_rs1"},   unit_rs1,   32'h0);
    chk32({tag, "_unit_rs2"},   {27'b0, unit_rs2}, 32'h0);
    chk1 ({tag, "_err"},        err,        1'b0);
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle after inputs settle.
  logic        hold_prev = 1'b0;
  logic [31:0] rd_prev   = '0;

  initial forever begin
    @(negedge clock);
    #2;
    if (!resetn) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready && record_push) begin
        exp_q.push_back(in_rs1 ^ {27'b0, in_rs2});
        pushes++;
      end
      if (unit_start) begin
        starts++;
        chk1("start_while_busy", unit_busy, 1'b0);
      end
      if (hold_prev) begin
        chk1 ("hold_valid", out_valid, 1'b1);
        chk32("hold_rd", out_rd, rd_prev);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk1("unexpected_result", out_valid, 1'b0);
        else                   chk32("result_order", out_rd, exp_q.pop_front());
        rx++;
      end
      hold_prev = out_valid && !out_ready;
      rd_prev   = out_rd;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0;
    int r0;
    int p0;
    int t;

    // Reset and idle
    repeat (2) tick();
    chk_reset_values("in_reset");
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("idle_in_ready",   in_ready,   1'b1);
      chk1("idle_out_valid",  out_valid,  1'b0);
      chk1("idle_unit_start", unit_start, 1'b0);
      chk1("idle_err",        err,        1'b0);
    end

    // Single op: push at edge 0
    in_rs1 = 32'h12345678; in_rs2 = 5'h1f; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk1("single_e0_start", unit_start, 1'b0);
    tick();
    chk1 ("single_e1_start", unit_start, 1'b1);
    chk32("single_e1_rs1", unit_rs1, 32'h12345678);
    chk32("single_e1_rs2", {27'b0, unit_rs2}, 32'h1f);
    tick();
    chk1 ("single_e2_start", unit_start, 1'b0);
    chk32("single_e2_rs1_hold", unit_rs1, 32'h12345678);
    repeat (4) tick();
    chk1("single_e6_valid", out_valid, 1'b0);
    tick();
    chk1 ("single_e7_valid", out_valid, 1'b1);
    chk32("single_e7_rd", out_rd, 32'h12345667);
    tick();
    chk1 ("single_e8_valid", out_valid, 1'b1);
    chk32("single_e8_rd", out_rd, 32'h12345667);
    out_ready = 1'b1;
    tick();
    chk1("single_e9_cleared", out_valid, 1'b0);
    out_ready = 1'b0;

    // Full FIFO with out_ready low
    s0 = starts; r0 = rx; p0 = pushes;
    in_rs2 = 5'h0;
    for (int k = 1; k <= 5; k++) begin
      in_rs1 = 32'(k); in_valid = 1'b1;
      chk1("fill_in_ready", in_ready, 1'b1);
      tick();
    end
    in_rs1 = 32'd6;
    chk1("full_in_ready", in_ready, 1'b0);
    repeat (12) tick();
    chk32("full_one_start", 32'(starts - s0), 32'd1);
    chk1 ("full_out_valid", out_valid, 1'b1);
    chk32("full_out_rd", out_rd, 32'd1);
    chk1 ("full_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    t = 0;
    while ((rx - r0) < 6 && t < 300) begin
      if ((pushes - p0) >= 6) in_valid = 1'b0;
      tick();
      t++;
    end
    in_valid = 1'b0;
    chk32("full_results", 32'(rx - r0), 32'd6);
    chk32("full_pushes", 32'(pushes - p0), 32'd6);
    chk32("full_starts", 32'(starts - s0), 32'd6);
    out_ready = 1'b0;
    tick();

    // Random gaps and random out_ready
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_rs1 = $urandom; in_rs2 = 5'($urandom_range(0, 31)); in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) chk1("rand_accept_timeout", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat ($urandom_range(1, 9)) tick();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    chk32("rand_drain", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    out_ready = 1'b0;
    tick();

`ifdef TINYGZIP_FEEDER_WATCHDOG_EN
    // Watchdog: unit never answers
    record_push = 1'b0; no_done = 1'b1;
    in_rs1 = 32'hA5A50000; in_rs2 = 5'h3; in_valid = 1'b1;
    tick(); in_valid = 1'b0; record_push = 1'b1;
    tick();
    chk1("wd_start", unit_start, 1'b1);
    repeat (63) tick();
    chk1("wd_err_before", err, 1'b0);
    tick();
    chk1("wd_err_at_64", err, 1'b1);
    no_done = 1'b0;
    in_rs1 = 32'h000000F0; in_rs2 = 5'h0f; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    chk1("wd_reissue", unit_start, 1'b1);
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    chk32("wd_drain", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    out_ready = 1'b0;
`else
    chk1("no_wd_err", err, 1'b0);
`endif

    // Reset mid-operation with three entries queued
    in_valid = 1'b1; in_rs2 = 5'h0;
    in_rs1 = 32'h100; tick();
    in_rs1 = 32'h101; tick();
    in_rs1 = 32'h102; tick();
    in_rs1 = 32'h103; tick();
    in_valid = 1'b0;
    chk1 ("pre_reset_busy", unit_busy, 1'b1);
    chk32("pre_reset_rs1", unit_rs1, 32'h100);
    resetn = 1'b0;
    #1;
    chk_reset_values("mid_reset");
    tick();
    resetn = 1'b1;
    s0 = starts;
    tick();
    force_done = 1'b1; force_rd = 32'hDEADBEEF;
    tick();
    force_done = 1'b0;
    repeat (3) tick();
    chk1 ("stale_out_valid", out_valid, 1'b0);
    chk32("stale_out_rd", out_rd, 32'h0);
    chk1 ("stale_in_ready", in_ready, 1'b1);
    chk32("stale_no_start", 32'(starts - s0), 32'd0);
`ifdef TINYGZIP_FEEDER_WATCHDOG_EN
    chk1("stale_err", err, 1'b1);
`else
    chk1("stale_err", err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
